// File: rtl/pakage_load_ctrl_pkg.sv
// Shared widths and FSM encoding for the package staging RAM sequencer.
package pakage_load_ctrl_pkg;

  localparam int unsigned PKG_DATA_W = 512;
  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned RAM_IDX_W  = 8;
  localparam int unsigned LEVEL_W    = RAM_IDX_W + 1;
  localparam int unsigned OFF_W      = 12;
  localparam int unsigned SPAN_W     = OFF_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } ld_state_e;

endpackage

// File: rtl/pakage_ptr_ctrl.sv
// Write/read indices and fill level of the staging RAM; one slot is kept free.
module pakage_ptr_ctrl
  import pakage_load_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkg_valid,
  input  logic                 rd_beat,
  output logic [RAM_IDX_W-1:0] wr_ptr,
  output logic [RAM_IDX_W-1:0] rd_ptr,
  output logic [LEVEL_W-1:0]   level,
  output logic                 pkg_ready
);

  logic wr_beat;

  assign pkg_ready = (level < LEVEL_W'(DEPTH - 1));
  assign wr_beat   = pkg_valid & pkg_ready;

  // Pointer advance modulo DEPTH and level bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_beat) begin
        wr_ptr <= (wr_ptr == RAM_IDX_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_beat) begin
        rd_ptr <= (rd_ptr == RAM_IDX_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_beat, rd_beat})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pakage_load_ctrl.sv
// Staging RAM sequencer: back-pressure, DDR burst FSM, wrapping region addresses, flush.
module pakage_load_ctrl
  import pakage_load_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned BURST_LEN    = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned REGION_BEATS = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkg_valid,
  output logic                 pkg_ready,
  input  logic                 flush,
  output logic                 flush_done,
  output logic [RAM_IDX_W-1:0] wr_ram_cnt,
  output logic [RAM_IDX_W-1:0] rd_ram_cnt,
  output logic                 ddr_wr_req,
  input  logic                 ddr_wr_ack,
  output logic [31:0]          ddr_wr_addr,
  output logic [7:0]           ddr_wr_len,
  output logic                 ddr_wr_valid,
  input  logic                 ddr_wr_data_ready,
  output logic                 ddr_wr_last,
  output logic [LEVEL_W-1:0]   level
);

  ld_state_e          state_q, state_d;
  logic [7:0]         len_q;
  logic [7:0]         beat_cnt_q;
  logic [OFF_W-1:0]   beat_off_q;
  logic               flush_pend_q;
  logic               rd_beat;
  logic [SPAN_W-1:0]  room_c;
  logic [SPAN_W-1:0]  burst_n_c;
  logic [SPAN_W-1:0]  off_sum_c;

  assign rd_beat = ddr_wr_valid & ddr_wr_data_ready;

  pakage_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .pkg_valid (pkg_valid),
    .rd_beat   (rd_beat),
    .wr_ptr    (wr_ram_cnt),
    .rd_ptr    (rd_ram_cnt),
    .level     (level),
    .pkg_ready (pkg_ready)
  );

  assign ddr_wr_addr = BASE_ADDR + 32'(beat_off_q) * 32'(BEAT_BYTES);
  assign ddr_wr_len  = len_q;
  assign off_sum_c   = SPAN_W'(beat_off_q) + SPAN_W'(len_q) + SPAN_W'(1);

  // Burst size: buffered beats capped at BURST_LEN and at the room left in the region.
  always_comb begin
    room_c    = SPAN_W'(REGION_BEATS) - SPAN_W'(beat_off_q);
    burst_n_c = SPAN_W'(level);
    if (burst_n_c > SPAN_W'(BURST_LEN)) burst_n_c = SPAN_W'(BURST_LEN);
    if (burst_n_c > room_c)             burst_n_c = room_c;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (level >= LEVEL_W'(BURST_LEN) || (flush_pend_q && level != '0)) state_d = REQ;
      REQ:  if (ddr_wr_ack) state_d = DATA;
      DATA: if (rd_beat && ddr_wr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state only.
  always_comb begin
    ddr_wr_req   = 1'b0;
    ddr_wr_valid = 1'b0;
    ddr_wr_last  = 1'b0;
    flush_done   = 1'b0;
    case (state_q)
      IDLE: flush_done = flush_pend_q && (level == '0);
      REQ:  ddr_wr_req = 1'b1;
      DATA: begin
        ddr_wr_valid = 1'b1;
        ddr_wr_last  = (beat_cnt_q == len_q);
      end
      default: ;
    endcase
  end

  // Burst length latch, beat counter, region offset and flush tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      beat_cnt_q   <= '0;
      beat_off_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == REQ) begin
        len_q <= 8'(burst_n_c - SPAN_W'(1));
      end
      if (state_q != DATA)  beat_cnt_q <= '0;
      else if (rd_beat)     beat_cnt_q <= beat_cnt_q + 1'b1;
      if (rd_beat && ddr_wr_last) begin
        beat_off_q <= (off_sum_c == SPAN_W'(REGION_BEATS)) ? '0 : OFF_W'(off_sum_c);
      end
      if (flush_done)  flush_pend_q <= 1'b0;
      else if (flush)  flush_pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pakage_load_ctrl.sv
// Directed bench for pakage_load_ctrl with a 32-beat region to exercise address wrap.
module tb_pakage_load_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic        pkg_valid;
  logic        pkg_ready;
  logic        flush;
  logic        flush_done;
  logic [7:0]  wr_ram_cnt;
  logic [7:0]  rd_ram_cnt;
  logic        ddr_wr_req;
  logic        ddr_wr_ack;
  logic [31:0] ddr_wr_addr;
  logic [7:0]  ddr_wr_len;
  logic        ddr_wr_valid;
  logic        ddr_wr_data_ready;
  logic        ddr_wr_last;
  logic [8:0]  level;

  logic [31:0] ram [256];
  logic [31:0] pkg_data;
  logic [31:0] burst_addr [32];
  logic [7:0]  burst_len [32];
  logic [7:0]  cur_len;
  int unsigned wr_tag, exp_rd_tag, burst_cnt, fd_cnt, bidx, start_tag;
  int          n_cmp, n_fail;

  pakage_load_ctrl #(
    .DEPTH        (256),
    .BURST_LEN    (16),
    .BASE_ADDR    (BASE),
    .REGION_BEATS (32)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pkg_valid         (pkg_valid),
    .pkg_ready         (pkg_ready),
    .flush             (flush),
    .flush_done        (flush_done),
    .wr_ram_cnt        (wr_ram_cnt),
    .rd_ram_cnt        (rd_ram_cnt),
    .ddr_wr_req        (ddr_wr_req),
    .ddr_wr_ack        (ddr_wr_ack),
    .ddr_wr_addr       (ddr_wr_addr),
    .ddr_wr_len        (ddr_wr_len),
    .ddr_wr_valid      (ddr_wr_valid),
    .ddr_wr_data_ready (ddr_wr_data_ready),
    .ddr_wr_last       (ddr_wr_last),
    .level             (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Staging RAM: written every edge at the write index.
  always @(posedge clk) ram[wr_ram_cnt] <= pkg_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      pkg_valid = 1'b1;
      pkg_data  = wr_tag;
      acc       = pkg_ready;
      tick();
      if (acc) wr_tag++;
    end
    pkg_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned lvl, input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (level == 9'(lvl) && !ddr_wr_req && !ddr_wr_valid) break;
      tick();
    end
    chk(tag, 32'(level), lvl);
    chk({tag, "_busy"}, 32'({ddr_wr_req, ddr_wr_valid}), 0);
  endtask

  task automatic wait_fd(input int unsigned tgt, input string tag);
    for (int i = 0; i < 500; i++) begin
      if (fd_cnt >= tgt) break;
      tick();
    end
    chk(tag, fd_cnt, tgt);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (ddr_wr_valid) break;
      tick();
    end
    chk(tag, 32'(ddr_wr_valid), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(pkg_ready), 1);
    chk({tag, "_req"},   32'(ddr_wr_req), 0);
    chk({tag, "_valid"}, 32'(ddr_wr_valid), 0);
    chk({tag, "_last"},  32'(ddr_wr_last), 0);
    chk({tag, "_fdone"}, 32'(flush_done), 0);
    chk({tag, "_wrcnt"}, 32'(wr_ram_cnt), 0);
    chk({tag, "_rdcnt"}, 32'(rd_ram_cnt), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_len"},   32'(ddr_wr_len), 0);
    chk({tag, "_addr"},  ddr_wr_addr, BASE);
  endtask

  // DDR-side monitor: logs burst commands, checks data order and last flag, counts flush_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      bidx = 0;
    end else begin
      if (ddr_wr_req && ddr_wr_ack) begin
        if (burst_cnt < 32) begin
          burst_addr[burst_cnt] = ddr_wr_addr;
          burst_len[burst_cnt]  = ddr_wr_len;
        end
        burst_cnt++;
        cur_len = ddr_wr_len;
        bidx    = 0;
      end
      if (ddr_wr_valid && ddr_wr_data_ready) begin
        chk("rd_data", ram[rd_ram_cnt], exp_rd_tag);
        chk("rd_last", 32'(ddr_wr_last), 32'(bidx == 32'(cur_len)));
        exp_rd_tag++;
        bidx = ddr_wr_last ? 0 : bidx + 1;
      end
      if (flush_done) fd_cnt++;
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    wr_tag = 0; exp_rd_tag = 0; burst_cnt = 0; fd_cnt = 0; bidx = 0; cur_len = '0;
    rst_n = 1'b1; pkg_valid = 1'b0; flush = 1'b0; pkg_data = '0;
    ddr_wr_ack = 1'b1; ddr_wr_data_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #6;
    chk_reset_outputs("rst");
    #4 rst_n = 1'b1;
    tick();

    // One full burst: request rises the cycle after level hits 16
    push(16);
    chk("t1_level16", 32'(level), 16);
    chk("t1_req_pre", 32'(ddr_wr_req), 0);
    tick();
    chk("t1_req", 32'(ddr_wr_req), 1);
    chk("t1_len", 32'(ddr_wr_len), 15);
    chk("t1_addr", ddr_wr_addr, BASE);
    wait_idle(0, "t1_drain");
    chk("t1_bursts", burst_cnt, 1);
    chk("t1_rdtag", exp_rd_tag, 16);
    chk("t1_wrcnt", 32'(wr_ram_cnt), 16);
    chk("t1_rdcnt", 32'(rd_ram_cnt), 16);

    // Flush of a 5-beat partial burst, then a 3-beat one
    push(5);
    pulse_flush();
    wait_fd(1, "t2_fdone1");
    chk("t2_addr1", burst_addr[1], BASE + 32'h400);
    chk("t2_len1", 32'(burst_len[1]), 4);
    chk("t2_level", 32'(level), 0);
    repeat (3) tick();
    chk("t2_fd_once", fd_cnt, 1);
    push(3);
    pulse_flush();
    wait_fd(2, "t2_fdone2");
    chk("t2_addr2", burst_addr[2], BASE + 32'h540);
    chk("t2_len2", 32'(burst_len[2]), 2);

    // Region end at offset 24: burst clipped to 8 beats, next wraps to base
    push(16);
    wait_idle(8, "t4_clip");
    chk("t4_bursts", burst_cnt, 4);
    chk("t4_addr3", burst_addr[3], BASE + 32'h600);
    chk("t4_len3", 32'(burst_len[3]), 7);
    push(8);
    wait_idle(0, "t4_drain");
    chk("t4_addr4", burst_addr[4], BASE);
    chk("t4_len4", 32'(burst_len[4]), 15);
    chk("t4_order", exp_rd_tag, wr_tag);

    // Simultaneous write and read every cycle keeps level constant
    ddr_wr_data_ready = 1'b0;
    push(16);
    wait_valid("t5_valid");
    pkg_valid = 1'b1;
    ddr_wr_data_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pkg_data = wr_tag;
      tick();
      wr_tag++;
      chk("t5_level", 32'(level), 16);
    end
    pkg_valid = 1'b0;
    wait_idle(0, "t5_drain");
    chk("t5_bursts", burst_cnt, 7);
    chk("t5_addr5", burst_addr[5], BASE + 32'h400);
    chk("t5_addr6", burst_addr[6], BASE);

    // Fill to capacity with the command held off, then drain in order
    ddr_wr_ack = 1'b0;
    start_tag = wr_tag;
    push(300);
    chk("t3_accepted", wr_tag - start_tag, 255);
    chk("t3_level", 32'(level), 255);
    chk("t3_ready0", 32'(pkg_ready), 0);
    chk("t3_req_held", 32'(ddr_wr_req), 1);
    ddr_wr_ack = 1'b1;
    tick();
    chk("t3_valid", 32'(ddr_wr_valid), 1);
    chk("t3_ready_still0", 32'(pkg_ready), 0);
    tick();
    chk("t3_ready1", 32'(pkg_ready), 1);
    chk("t3_level254", 32'(level), 254);
    wait_idle(15, "t3_residue");
    pulse_flush();
    wait_fd(3, "t3_fdone");
    chk("t3_bursts", burst_cnt, 23);
    chk("t3_len21", 32'(burst_len[21]), 15);
    chk("t3_addr21", burst_addr[21], BASE + 32'h400);
    chk("t3_len22", 32'(burst_len[22]), 14);
    chk("t3_addr22", burst_addr[22], BASE);
    chk("t3_order", exp_rd_tag, wr_tag);
    chk("t3_level0", 32'(level), 0);

    // Reset in the middle of a data phase
    ddr_wr_data_ready = 1'b0;
    push(16);
    wait_valid("t6_valid");
    chk("t6_addr", ddr_wr_addr, BASE + 32'h3C0);
    chk("t6_len", 32'(ddr_wr_len), 15);
    #3 rst_n = 1'b0;
    #2;
    chk_reset_outputs("t6_async");
    #3 rst_n = 1'b1;
    ddr_wr_data_ready = 1'b1;
    tick();
    chk("t6_wrcnt", 32'(wr_ram_cnt), 0);
    chk("t6_rdcnt", 32'(rd_ram_cnt), 0);
    chk("t6_ready", 32'(pkg_ready), 1);
    chk("t6_idle", 32'({ddr_wr_req, ddr_wr_valid}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
